jtkcpu_mul: RTL and testbench

- Iterative shift-add multiplier. Serves as the responder side of the ALU's start/busy arithmetic handshake, the same handshake the ALU uses with its divider.
- Executes MUL (8x8 -> 16, A*B) and LMUL (16x16 -> 32) over several cen cycles.
- Returns the product plus C and Z flags to the ALU / register writeback.
- Sits beside the divider under jtkcpu_alu; its busy is ORed into the ALU busy.

---
 rtl/jtkcpu_mul.sv | 103 ++++++++++
 tb/tb_jtkcpu_mul.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/jtkcpu_mul.sv
// Iterative unsigned shift-add multiplier (8x8->16 / 16x16->32) on the ALU start/busy handshake.
// Optional JTKCPU_MUL_RADIX4_EN retires two multiplier bits per cen cycle.
module jtkcpu_mul (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        start,
  input  logic        len,
  input  logic [15:0] op0,
  input  logic [15:0] op1,
  output logic        busy,
  output logic        done,
  output logic [31:0] prod,
  output logic        c,
  output logic        z
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

`ifdef JTKCPU_MUL_RADIX4_EN
  localparam logic [4:0] N8  = 5'd4;
  localparam logic [4:0] N16 = 5'd8;
`else
  localparam logic [4:0] N8  = 5'd8;
  localparam logic [4:0] N16 = 5'd16;
`endif

  logic [1:0]  st;
  logic [4:0]  cnt;
  logic        len_q;
  logic [15:0] mcand;
  logic [31:0] r;       // {accumulator, multiplier}; the product shifts in from the top
  logic [31:0] r_nxt;
  logic [31:0] p_nxt;

`ifdef JTKCPU_MUL_RADIX4_EN
  logic [17:0] addend;
  logic [17:0] sum;
  always_comb begin
    case (r[1:0])
      2'd0:    addend = 18'd0;
      2'd1:    addend = {2'b00, mcand};
      2'd2:    addend = {1'b0, mcand, 1'b0};
      default: addend = {1'b0, mcand, 1'b0} + {2'b00, mcand};
    endcase
    sum   = {2'b00, r[31:16]} + addend;
    r_nxt = {sum, r[15:2]};
  end
`else
  logic [16:0] sum;
  always_comb begin
    sum   = {1'b0, r[31:16]} + (r[0] ? {1'b0, mcand} : 17'd0);
    r_nxt = {sum, r[15:1]};
  end
`endif

  // After only 8 steps the 8x8 product sits 8 bits up in the register
  assign p_nxt = len_q ? r_nxt : {16'h0000, r_nxt[23:8]};

  assign busy = (st == RUN);
  assign done = (st == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= IDLE;
      cnt   <= 5'd0;
      len_q <= 1'b0;
      mcand <= 16'h0000;
      r     <= 32'h0000_0000;
      prod  <= 32'h0000_0000;
      c     <= 1'b0;
      z     <= 1'b0;
    end else if (cen) begin
      case (st)
        IDLE, DONE: begin
          if (start) begin
            st    <= RUN;
            len_q <= len;
            mcand <= len ? op0 : {8'h00, op0[7:0]};
            r     <= len ? {16'h0000, op1} : {24'h00_0000, op1[7:0]};
            cnt   <= len ? N16 : N8;
          end else begin
            st <= IDLE;
          end
        end
        RUN: begin
          r   <= r_nxt;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            st   <= DONE;
            prod <= p_nxt;
            c    <= len_q ? p_nxt[31] : p_nxt[15];
            z    <= (p_nxt == 32'h0000_0000);
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtkcpu_mul.sv
// Self-checking bench for jtkcpu_mul: directed corner cases plus randomized ops against an arithmetic model.
module tb_jtkcpu_mul;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b0;
  logic        start = 1'b0;
  logic        len = 1'b0;
  logic [15:0] op0 = 16'h0;
  logic [15:0] op1 = 16'h0;
  logic        busy, done, c, z;
  logic [31:0] prod;

  int errors = 0;
  int checks = 0;

`ifdef JTKCPU_MUL_RADIX4_EN
  localparam int N8 = 4, N16 = 8;
`else
  localparam int N8 = 8, N16 = 16;
`endif

  jtkcpu_mul dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .start(start), .len(len),
    .op0(op0), .op1(op1), .busy(busy), .done(done), .prod(prod), .c(c), .z(z)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_prod(input logic l, input logic [15:0] a, input logic [15:0] b);
    int unsigned x, y;
    x = l ? int'(a) : int'(a & 16'h00FF);
    y = l ? int'(b) : int'(b & 16'h00FF);
    return x * y;
  endfunction

  // Drives one operation to completion; reports result and enabled-edge counts
  task automatic run_op(input logic l, input logic [15:0] a, input logic [15:0] b, input bit gate,
                        output logic [31:0] p, output logic pc, output logic pz,
                        output int lat, output int busy_n, output int done_n, output bit timeout);
    bit seen;
    @(negedge clk);
    len = l; op0 = a; op1 = b; start = 1'b1; cen = 1'b1;
    @(negedge clk);
    start = 1'b0; op0 = 16'($urandom); op1 = 16'($urandom); len = 1'($urandom);
    lat = 1; busy_n = 0; done_n = 0; seen = 0; timeout = 1;
    p = 32'h0; pc = 1'b0; pz = 1'b0;
    for (int i = 0; i < 300; i++) begin
      cen = gate ? (i % 3 == 2) : 1'b1;
      if (busy && cen) busy_n++;
      if (done) begin
        if (!seen) begin p = prod; pc = c; pz = z; seen = 1; end
        if (cen) done_n++;
      end else if (seen) begin
        timeout = 0;
        break;
      end
      if (!seen && cen) lat++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cen = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (prod !== 32'h0) begin errors++; $display("FAIL reset_prod: got %h expected 0", prod); end
    checks++; if ({c, z} !== 2'b00) begin errors++; $display("FAIL reset_flags: got cz=%b expected 00", {c, z}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed_and_abort;
    logic [31:0] p; logic pc, pz; int lat, bn, dn; bit to;
    int done_seen;
    run_op(1'b1, 16'h1234, 16'h0002, 1'b0, p, pc, pz, lat, bn, dn, to);
    checks++; if (to) begin errors++; $display("FAIL dir_timeout: got timeout expected done"); end
    checks++; if (p !== 32'h0000_2468) begin errors++; $display("FAIL dir_prod: got %h expected 00002468", p); end
    checks++; if ({pc, pz} !== 2'b00) begin errors++; $display("FAIL dir_flags: got cz=%b expected 00", {pc, pz}); end
    checks++; if (bn !== N16) begin errors++; $display("FAIL dir_busy_len: got %0d expected %0d", bn, N16); end
    // Abort: reset asserted a few cycles into a new op
    @(negedge clk);
    len = 1'b1; op0 = 16'hFFFF; op1 = 16'h7777; start = 1'b1; cen = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (prod !== 32'h0) begin errors++; $display("FAIL abort_prod: got %h expected 0", prod); end
    @(negedge clk); rst_n = 1'b1;
    done_seen = 0;
    repeat (40) begin @(negedge clk); if (done) done_seen++; end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL abort_done: got %0d pulses expected 0", done_seen); end
  endtask

  task automatic test_max_zero;
    logic [31:0] p; logic pc, pz; int lat, bn, dn; bit to;
    run_op(1'b0, 16'hABFF, 16'hCDFF, 1'b0, p, pc, pz, lat, bn, dn, to);
    checks++; if (to || p !== 32'h0000_FE01) begin errors++; $display("FAIL max8_prod: got %h expected 0000fe01", p); end
    checks++; if ({pc, pz} !== 2'b10) begin errors++; $display("FAIL max8_flags: got cz=%b expected 10", {pc, pz}); end
    checks++; if (lat !== N8 + 1) begin errors++; $display("FAIL max8_latency: got %0d expected %0d", lat, N8 + 1); end
    run_op(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, p, pc, pz, lat, bn, dn, to);
    checks++; if (to || p !== 32'hFFFE_0001) begin errors++; $display("FAIL max16_prod: got %h expected fffe0001", p); end
    checks++; if ({pc, pz} !== 2'b10) begin errors++; $display("FAIL max16_flags: got cz=%b expected 10", {pc, pz}); end
    checks++; if (lat !== N16 + 1) begin errors++; $display("FAIL max16_latency: got %0d expected %0d", lat, N16 + 1); end
    run_op(1'b1, 16'hBEEF, 16'h0000, 1'b0, p, pc, pz, lat, bn, dn, to);
    checks++; if (to || p !== 32'h0) begin errors++; $display("FAIL zero_prod: got %h expected 0", p); end
    checks++; if ({pc, pz} !== 2'b01) begin errors++; $display("FAIL zero_flags: got cz=%b expected 01", {pc, pz}); end
    // 8x8 with only upper operand bits set is also zero
    run_op(1'b0, 16'h1200, 16'h3400, 1'b0, p, pc, pz, lat, bn, dn, to);
    checks++; if (to || p !== 32'h0 || pz !== 1'b1) begin errors++; $display("FAIL zero8: got %h z=%b expected 0 z=1", p, pz); end
  endtask

  task automatic test_cen_gating;
    logic [31:0] p, e; logic pc, pz; int lat, bn, dn; bit to;
    logic [15:0] a, b;
    a = 16'($urandom); b = 16'($urandom);
    e = model_prod(1'b1, a, b);
    run_op(1'b1, a, b, 1'b1, p, pc, pz, lat, bn, dn, to);
    checks++; if (to || p !== e) begin errors++; $display("FAIL gate_prod: got %h expected %h", p, e); end
    checks++; if (bn !== N16) begin errors++; $display("FAIL gate_busy: got %0d expected %0d", bn, N16); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL gate_done_width: got %0d expected 1", dn); end
    checks++; if (lat !== N16 + 1) begin errors++; $display("FAIL gate_latency: got %0d expected %0d", lat, N16 + 1); end
  endtask

  task automatic test_protocol;
    logic [15:0] a, b, a2, b2;
    logic [31:0] e1, e2;
    a = 16'($urandom); b = 16'($urandom) | 16'h0001;
    a2 = 16'($urandom); b2 = 16'($urandom);
    e1 = model_prod(1'b1, a, b);
    e2 = model_prod(1'b0, a2, b2);
    @(negedge clk);
    len = 1'b1; op0 = a; op1 = b; start = 1'b1; cen = 1'b1;
    for (int i = 0; i < N16 - 1; i++) begin
      @(negedge clk);
      op0 = 16'($urandom); op1 = 16'($urandom); len = 1'($urandom);
    end
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy: got %b expected 1", busy); end
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    checks++; if (!done || prod !== e1) begin errors++; $display("FAIL hold_prod: got %h done=%b expected %h", prod, done, e1); end
    // Back-to-back: new start presented during the done cycle
    len = 1'b0; op0 = a2; op1 = b2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL b2b_busy: got busy,done=%b expected 10", {busy, done}); end
    checks++; if (prod !== e1) begin errors++; $display("FAIL b2b_prod_held: got %h expected %h", prod, e1); end
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    checks++; if (!done || prod !== e2) begin errors++; $display("FAIL b2b_prod: got %h done=%b expected %h", prod, done, e2); end
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [31:0] p, e; logic pc, pz, l, ec; int lat, bn, dn; bit to, g;
    logic [15:0] a, b;
    for (int n = 0; n < 400; n++) begin
      a = 16'($urandom); b = 16'($urandom); l = 1'($urandom); g = ($urandom_range(0, 3) == 0);
      if (n % 17 == 0) a = 16'hFFFF;
      if (n % 23 == 0) b = 16'h0000;
      e = model_prod(l, a, b);
      ec = l ? e[31] : e[15];
      run_op(l, a, b, g, p, pc, pz, lat, bn, dn, to);
      checks++; if (to || p !== e) begin errors++; $display("FAIL rand_prod: l=%b a=%h b=%h got %h expected %h", l, a, b, p, e); end
      checks++; if ({pc, pz} !== {ec, e == 32'h0}) begin errors++; $display("FAIL rand_flags: got cz=%b expected %b", {pc, pz}, {ec, e == 32'h0}); end
      checks++; if (lat !== (l ? N16 : N8) + 1 || dn !== 1) begin errors++; $display("FAIL rand_timing: got lat=%0d done=%0d expected %0d/1", lat, dn, (l ? N16 : N8) + 1); end
    end
  endtask

  initial begin
    test_reset();
    test_directed_and_abort();
    test_max_zero();
    test_cen_gating();
    test_protocol();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
